// File: rtl/act4_pkg.sv
// act4_pkg
// Shared types and sizes for the Act4 truth-table checker.
//   state_t   checker FSM states
//   TT_W      width of the captured truth table (8 vectors x 4 outputs)
//   NUM_VEC   number of input vectors swept ({A,B,C} = 0..7)
//   SETTLE_W  width of the settle down-counter
//   nib_sel   bit offset of the nibble that belongs to a vector index
package act4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int TT_W     = 32;
  localparam int NUM_VEC  = 8;
  localparam int SETTLE_W = 4;

  function automatic logic [4:0] nib_sel(input logic [2:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/act4_settle_timer.sv
// act4_settle_timer
// Loadable down-counter that measures how long each vector is held.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_val (has priority over counting)
//   load_val     reload value
//   en           count down while nonzero
//   zero         counter has reached terminal count
module act4_settle_timer
  import act4_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/act4_tt_checker.sv
// act4_tt_checker
// Sweeps A,B,C through all eight combinations, holds each vector for
// SETTLE_CYCLES+1 cycles, captures {F4,F3,F2,F1} into a 32-bit truth table
// and compares the enabled outputs against EXPECTED.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a sweep (only honoured in IDLE)
//   F1..F4              outputs of the combinational module under test
//   A, B, C             registered stimulus, A is the index MSB
//   busy                sweep in progress
//   done                one-cycle pulse at sweep completion
//   pass                no mismatches; valid from done until next start
//   tt                  captured table, nibble k = {F4,F3,F2,F1} at index k
//   fail_cnt, fail_idx  mismatch count and index of the first mismatch
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; results of the last sweep are held
// SETTLE | current vector driven, timer running; sample at zero
// DONE   | done pulse cycle; start ignored, returns to IDLE
module act4_tt_checker
  import act4_pkg::*;
#(
  parameter int              SETTLE_CYCLES = 2,  // legal 1..15
  parameter logic [TT_W-1:0] EXPECTED      = 32'h0000_1100,
  parameter logic [3:0]      CHECK_MASK    = 4'b0001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            F1,
  input  logic            F2,
  input  logic            F3,
  input  logic            F4,
  output logic            A,
  output logic            B,
  output logic            C,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] tt,
  output logic [3:0]      fail_cnt,
  output logic [2:0]      fail_idx
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [2:0]          LAST_IDX  = 3'(NUM_VEC - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] f_vec;
  logic [3:0] exp_nib;
  logic [3:0] fail_cnt_nxt;
  logic       mismatch;
  logic       sample;
  logic       last_vec;
  logic       timer_load;
  logic       timer_zero;

  assign f_vec        = {F4, F3, F2, F1};
  assign exp_nib      = EXPECTED[nib_sel(idx) +: 4];
  assign mismatch     = |((f_vec ^ exp_nib) & CHECK_MASK);
  assign fail_cnt_nxt = fail_cnt + {3'b000, mismatch};
  assign sample       = (state == SETTLE) && timer_zero;
  assign last_vec     = (idx == LAST_IDX);

  // Reload on an accepted start and after every sample except the last,
  // so each vector sees exactly SETTLE_CYCLES+1 edges.
  assign timer_load   = ((state == IDLE) && start) || (sample && !last_vec);

  act4_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LD),
    .en       (state == SETTLE),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      {A, B, C} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      tt        <= '0;
      fail_cnt  <= '0;
      fail_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tt        <= '0;
            fail_cnt  <= '0;
            fail_idx  <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            {A, B, C} <= 3'b000;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (sample) begin
            tt[nib_sel(idx) +: 4] <= f_vec;
            if (mismatch) begin
              fail_cnt <= fail_cnt_nxt;
              if (fail_cnt == '0) begin
                fail_idx <= idx;
              end
            end
            if (!last_vec) begin
              idx       <= idx + 3'd1;
              {A, B, C} <= idx + 3'd1;
            end else begin
              {A, B, C} <= 3'b000;
              busy      <= 1'b0;
              done      <= 1'b1;
              // Include this last vector's verdict in pass.
              pass      <= (fail_cnt_nxt == '0);
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act4_tt_checker.sv
module tb_act4_tt_checker;

  localparam logic [31:0] EXP_TT = 32'h0000_1100;
  localparam logic [3:0]  MASK   = 4'b0001;

  typedef struct {
    logic [31:0] tt;
    logic [3:0]  fc;
    logic [2:0]  fi;
    logic        pass;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode = 0;
  int   sel = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: S=2, instance 1: S=1
  logic        a0, b0, c0, busy0, done0, pass0;
  logic [31:0] tt0;
  logic [3:0]  fc0, f0;
  logic [2:0]  fi0;
  logic        a1, b1, c1, busy1, done1, pass1;
  logic [31:0] tt1;
  logic [3:0]  fc1, f1;
  logic [2:0]  fi1;

  // {F4,F3,F2,F1}; mode 0 good (F1=~A&B), 1 stuck-A (F1=B), 2 good with F2 tied high
  function automatic logic [3:0] f_model(input int m, input logic a, input logic b, input logic c);
    logic o1;
    logic o2;
    o1 = (m == 1) ? b : (~a & b);
    o2 = (m == 2);
    return {1'b0, 1'b0, o2, o1};
  endfunction

  always_comb f0 = f_model(mode, a0, b0, c0);
  always_comb f1 = f_model(mode, a1, b1, c1);

  act4_tt_checker #(.SETTLE_CYCLES(2), .EXPECTED(EXP_TT), .CHECK_MASK(MASK)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .F1(f0[0]), .F2(f0[1]), .F3(f0[2]), .F4(f0[3]),
    .A(a0), .B(b0), .C(c0), .busy(busy0), .done(done0), .pass(pass0),
    .tt(tt0), .fail_cnt(fc0), .fail_idx(fi0)
  );

  act4_tt_checker #(.SETTLE_CYCLES(1), .EXPECTED(EXP_TT), .CHECK_MASK(MASK)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .F1(f1[0]), .F2(f1[1]), .F3(f1[2]), .F4(f1[3]),
    .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1), .pass(pass1),
    .tt(tt1), .fail_cnt(fc1), .fail_idx(fi1)
  );

  logic [2:0]  abc;
  logic        busy, done, pass;
  logic [31:0] tt;
  logic [3:0]  fc;
  logic [2:0]  fi;

  always_comb begin
    abc  = {a0, b0, c0};
    busy = busy0;
    done = done0;
    pass = pass0;
    tt   = tt0;
    fc   = fc0;
    fi   = fi0;
    if (sel != 0) begin
      abc  = {a1, b1, c1};
      busy = busy1;
      done = done1;
      pass = pass1;
      tt   = tt1;
      fc   = fc1;
      fi   = fi1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_sweep(input int m);
    exp_t        e;
    logic [31:0] et;
    logic [3:0]  nib;
    logic [2:0]  kk;
    et     = EXP_TT;
    e.tt   = '0;
    e.fc   = '0;
    e.fi   = '0;
    for (int k = 0; k < 8; k++) begin
      kk = 3'(k);
      nib = f_model(m, kk[2], kk[1], kk[0]);
      e.tt[k*4 +: 4] = nib;
      if (((nib ^ et[k*4 +: 4]) & MASK) != 4'b0000) begin
        if (e.fc == 4'd0) e.fi = kk;
        e.fc = e.fc + 4'd1;
      end
    end
    e.pass = (e.fc == 4'd0);
    return e;
  endfunction

  // Entered and left on a negedge; start is raised immediately so a call
  // right after another sweep exercises the minimum restart spacing.
  task automatic run_sweep(input int m, input int s_sel, input bit extra);
    int   s;
    int   n;
    int   t0;
    bit   got;
    exp_t e;
    mode = m;
    sel  = s_sel;
    s    = (s_sel != 0) ? 1 : 2;
    sb.push_back(model_sweep(m));
    if (s_sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    chk("clr_tt", tt, 32'h0);
    chk("clr_fail_cnt", 32'(fc), 32'h0);
    chk("clr_pass", 32'(pass), 32'h0);
    chk("busy_rise", 32'(busy), 32'h1);
    got = 1'b0;
    for (int i = 0; i < 8 * (s + 1) + 10 && !got; i++) begin
      start0 = 1'b0;
      start1 = 1'b0;
      n = cyc - t0;
      if (extra && (n == 5 || n == 10)) begin
        if (s_sel != 0) start1 = 1'b1; else start0 = 1'b1;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        chk("done_edge", 32'(n), 32'(8 * (s + 1)));
        chk("abc_end", 32'(abc), 32'h0);
        chk("busy_fall", 32'(busy), 32'h0);
        if (sb.size() == 0) begin
          chk("sb_empty", 32'h0, 32'h1);
        end else begin
          e = sb.pop_front();
          chk("tt", tt, e.tt);
          chk("fail_cnt", 32'(fc), 32'(e.fc));
          chk("fail_idx", 32'(fi), 32'(e.fi));
          chk("pass", 32'(pass), 32'(e.pass));
        end
      end else begin
        if (n < 8 * (s + 1)) begin
          chk("abc_walk", 32'(abc), 32'(n / (s + 1)));
          chk("busy_walk", 32'(busy), 32'h1);
        end
        @(negedge clk);
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'h0, 32'h1);
      if (sb.size() != 0) e = sb.pop_front();
    end
    @(negedge clk);
    chk("done_one_pulse", 32'(done), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_abc"}, 32'(abc), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_pass"}, 32'(pass), 32'h0);
    chk({tag, "_tt"}, tt, 32'h0);
    chk({tag, "_fail_cnt"}, 32'(fc), 32'h0);
    chk({tag, "_fail_idx"}, 32'(fi), 32'h0);
  endtask

  task automatic reset_mid_sweep();
    mode   = 0;
    sel    = 0;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    // vectors 0..2 sampled by now; only index 2 has F1=1
    chk("mid_tt", tt, 32'h0000_0100);
    chk("mid_abc", 32'(abc), 32'h3);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abandon_no_done", 32'(done), 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 0, 1'b0);
    run_sweep(0, 0, 1'b0);
    run_sweep(1, 0, 1'b0);
    run_sweep(2, 0, 1'b1);
    reset_mid_sweep();
    run_sweep(0, 0, 1'b0);
    run_sweep(0, 1, 1'b0);
    run_sweep(1, 1, 1'b0);
    run_sweep(0, 1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
